mining_chunk_feeder: RTL and testbench
======================================

// Module: mining_chunk_feeder
// PURPOSE
//  Producer side of the mining chunk-load interface. Accepts the block
//  header as a 32-bit word stream (valid/ready) and assembles 512-bit chunks,
//  MSB-first. Hands each chunk to Preprocessing when Mining_FSM reports
//  LOAD (state==3'h1), and drives message/indirizzo/stopw toward it.
//  Replaces the behavioural loader used in simulation with synthesizable RTL.
// PARAMETERS
//  MSG_BITS  1024  total message length; multiple of 512; NCHUNK = MSG_BITS/512
//  WORD_W    32    input word width; 512 % WORD_W == 0; WPC = 512/WORD_W
//  ADDR_W    16    width of indirizzo
// PORTS
//  clock        in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  s_valid      in   1        input word valid
//  s_data       in   WORD_W   input word; first word = chunk bits [511-:WORD_W]
//  s_last       in   1        marks final word of the message
//  s_ready      out  1        feeder accepts s_data this cycle
//  state        in   3        Mining_FSM state; LOAD = 3'h1
//  message      out  512      chunk presented to Preprocessing
//  indirizzo    out  ADDR_W   index of chunk currently on message
//  stopw        out  1        all NCHUNK chunks handed off; sticky
//  underrun     out  1        sticky: LOAD seen with no chunk buffered
//  framing_err  out  1        sticky: s_last on wrong word, or missing on final word
// BEHAVIOUR
//  Reset (async, reset==0): message=0, indirizzo=0, stopw=0, s_ready=0,
//   underrun=0, framing_err=0, word count=0, chunk count=0. FSM -> FILL on the
//   first clock after release.
//  FSM: FILL -> FULL -> (handoff) -> FILL ... -> DONE.
//   FILL: s_ready=1. A word is accepted when s_valid&&s_ready. It is shifted
//    into the assembly buffer: buf <= {buf[511-WORD_W:0], s_data}.
//    After word WPC-1 is accepted, the state becomes FULL on the next cycle.
//   FULL: s_ready=0. On a clock edge where state==3'h1, the handoff happens:
//    message <= buf.
//    indirizzo <= chunk_cnt, where chunk_cnt is the number of earlier handoffs.
//    chunk_cnt++.
//    If chunk_cnt was NCHUNK-1, go to DONE; otherwise go to FILL.
//    Result: indirizzo is 0 for the first chunk and saturates at NCHUNK-1.
//   DONE: stopw=1 on the cycle after the final handoff. s_ready=0.
//    message and indirizzo hold. Further LOAD cycles are ignored.
//    Only reset leaves DONE.
//  LOAD while in FILL: message and indirizzo hold. underrun<=1.
//   The partial chunk continues to fill. No handoff occurs.
//  Handoff latency: message is valid on the cycle after the LOAD edge.
//  s_last framing:
//   s_last=1 on the accepted final word of chunk NCHUNK-1: normal.
//   s_last=1 on any other accepted word: framing_err<=1. The word is still used.
//   s_last=0 on the final word of chunk NCHUNK-1: framing_err<=1.
//  Words offered in DONE are not accepted (s_ready=0).
//  Reset mid-chunk discards the partial buffer. The next chunk restarts at word 0.
// CONFIGURATION
//  MINING_FEEDER_DBUF_EN defined:
//   Adds a second 512-bit buffer. While FULL, assembly of the next chunk
//    continues; s_ready stays 1 until both buffers are full.
//   Handoff and an accepted word in the same cycle are both honoured.
//   The buffers swap roles at handoff. Chunk order is preserved.
//   underrun is set only when both buffers are empty at LOAD.
//  MINING_FEEDER_DBUF_EN undefined:
//   Single buffer exactly as in BEHAVIOUR. s_ready=0 from FULL until handoff.
// STRUCTURE
//  Package mining_pkg:
//   ST_LOAD = 3'h1, CHUNK_W = 512, WPC, and the feeder state enum
//   (FILL, FULL, DONE).
//  Sub-module chunk_assembler:
//   WORD_W -> 512 shift register, word counter and 'complete' pulse.
//   Instantiated once, or twice under MINING_FEEDER_DBUF_EN.
//  Top level: FSM, handoff register, indirizzo/chunk counters, sticky flags.
// TESTING
//  1. MSG_BITS=1024; stream 32 words 0x00000000..0x0000001F (s_last on the
//     last); LOAD after each chunk fills.
//     -> 1st handoff: message[511:480]=0x0, indirizzo=0.
//     -> 2nd handoff: message[31:0]=0x1F, indirizzo=1; stopw=1 next cycle.
//  2. LOAD pulse after 5 words accepted.
//     -> underrun=1; message stays 0.
//     -> After 11 more words and LOAD: normal handoff.
//  3. s_last on word 7 of chunk 0 -> framing_err=1; words 8..15 still accepted.
//  4. Drive reset low mid-chunk 1 (word 9).
//     -> All outputs reach reset values asynchronously.
//     -> Restream of 32 words reproduces scenario 1.
//  5. In DONE: s_valid=1 and LOAD pulses -> s_ready=0; message, indirizzo,
//     stopw unchanged.
//  6. DBUF_EN: stream 32 words without waiting.
//     -> s_ready stays 1 throughout.
//     -> Two LOADs give chunks 0 then 1 in order.
//     -> Without DBUF_EN: s_ready=0 at word 16 until the first LOAD.

Source files
------------

// File: rtl/mining_pkg.sv
// mining_pkg: shared constants and the feeder state type for the mining
// chunk-load path.
package mining_pkg;

   // Mining_FSM state value that requests a chunk load.
   localparam logic [2:0] ST_LOAD = 3'h1;

   // Chunk geometry: 512-bit chunks built from 32-bit words by default.
   localparam int CHUNK_W    = 512;
   localparam int DEF_WORD_W = 32;
   localparam int WPC        = CHUNK_W / DEF_WORD_W;

   // F_INIT holds s_ready low for the first cycle after reset release.
   // FILL  : no complete chunk is waiting for handoff.
   // FULL  : the oldest buffer holds a complete chunk.
   // DONE  : every chunk has been handed off; only reset leaves it.
   typedef enum logic [1:0] {
      F_INIT = 2'd0,
      FILL   = 2'd1,
      FULL   = 2'd2,
      DONE   = 2'd3
   } feeder_state_e;

endpackage

// File: rtl/mining_chunk_feeder_chunk_assembler.sv
// chunk_assembler: shifts WORD_W-bit words into a 512-bit chunk, MSB-first,
// and raises 'complete' combinationally on the word that finishes a chunk.
module chunk_assembler
   import mining_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               word_en,
   input  logic [WORD_W-1:0]  word_data,
   output logic [CHUNK_W-1:0] chunk,
   output logic               complete
);

   localparam int WPC_L = CHUNK_W / WORD_W;
   localparam int WC_W  = (WPC_L > 1) ? $clog2(WPC_L) : 1;

   logic [WC_W-1:0] word_cnt_q;

   assign complete = word_en && (word_cnt_q == WC_W'(WPC_L - 1));

   // Position of the next word within the chunk; wraps after the last word.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         word_cnt_q <= '0;
      end else if (word_en) begin
         word_cnt_q <= complete ? '0 : word_cnt_q + 1'b1;
      end
   end

   // Shift register: the first word of a chunk ends up in bits [511-:WORD_W].
   // NOTE: the data shift register is deliberately not reset; the word counter
   // alone decides when its contents are meaningful, and every chunk fully
   // overwrites it before use.
   always_ff @(posedge clock) begin
      if (word_en) begin
         chunk <= {chunk[CHUNK_W-WORD_W-1:0], word_data};
      end
   end

endmodule

// File: rtl/mining_chunk_feeder.sv
// mining_chunk_feeder: producer side of the mining chunk-load interface.
// Assembles a word stream into 512-bit chunks and hands one chunk to
// Preprocessing on each LOAD cycle of Mining_FSM.
// Build option: MINING_FEEDER_DBUF_EN adds a second chunk buffer so assembly
// of the next chunk overlaps with waiting for LOAD.
module mining_chunk_feeder
   import mining_pkg::*;
#(
   parameter int MSG_BITS = 1024,
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               s_valid,
   input  logic [WORD_W-1:0]  s_data,
   input  logic               s_last,
   output logic               s_ready,
   input  logic [2:0]         state,
   output logic [CHUNK_W-1:0] message,
   output logic [ADDR_W-1:0]  indirizzo,
   output logic               stopw,
   output logic               underrun,
   output logic               framing_err
);

`ifdef MINING_FEEDER_DBUF_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif

   localparam int NCHUNK = MSG_BITS / CHUNK_W;
   localparam int CNT_W  = $clog2(NCHUNK + 1);

   feeder_state_e fsm_q, fsm_d;

   logic [1:0]              full_q;      // per-buffer "complete chunk waiting"
   logic                    wr_sel_q;    // buffer being assembled
   logic                    rd_sel_q;    // oldest buffer, next to hand off
   logic [CNT_W-1:0]        chunk_cnt_q; // chunks handed off so far
   logic [CNT_W-1:0]        fill_cnt_q;  // chunks fully assembled so far
   logic [1:0][CHUNK_W-1:0] asm_q;
   logic [1:0]              cmpl;

   logic word_acc, cmpl_now, load, handoff, last_fill, last_out;

   generate
      for (genvar g = 0; g < NBUF; g++) begin : g_asm
         chunk_assembler #(.WORD_W(WORD_W)) u_asm (
            .clock     (clock),
            .reset     (reset),
            .word_en   (word_acc && (wr_sel_q == 1'(g))),
            .word_data (s_data),
            .chunk     (asm_q[g]),
            .complete  (cmpl[g])
         );
      end
      if (NBUF < 2) begin : g_tie
         assign asm_q[1] = '0;
         assign cmpl[1]  = 1'b0;
      end
   endgenerate

   // Handshake, handoff qualification and next-state decode.
   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      s_ready   = 1'b0;
      fsm_d     = fsm_q;
      load      = (state == ST_LOAD);
      handoff   = (fsm_q == FULL) && load;
      last_fill = (fill_cnt_q == CNT_W'(NCHUNK - 1));
      last_out  = (chunk_cnt_q == CNT_W'(NCHUNK - 1));

      if (((fsm_q == FILL) || (fsm_q == FULL)) && !full_q[wr_sel_q] &&
          (fill_cnt_q != CNT_W'(NCHUNK))) begin
         s_ready = 1'b1;
      end
      word_acc = s_valid && s_ready;
      cmpl_now = |cmpl;

      case (fsm_q)
         F_INIT: fsm_d = FILL;
         FILL:   if (cmpl_now) fsm_d = FULL;
         FULL: begin
            if (handoff) begin
               if (last_out)                           fsm_d = DONE;
               else if (full_q[~rd_sel_q] || cmpl_now) fsm_d = FULL;
               else                                    fsm_d = FILL;
            end
         end
         DONE:    fsm_d = DONE;
         default: fsm_d = F_INIT;
      endcase
   end

   assign stopw = (fsm_q == DONE);

   // Feeder state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fsm_q <= F_INIT;
      else        fsm_q <= fsm_d;
   end

   // Buffer occupancy, ping-pong pointers and chunk counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         full_q      <= '0;
         wr_sel_q    <= 1'b0;
         rd_sel_q    <= 1'b0;
         fill_cnt_q  <= '0;
         chunk_cnt_q <= '0;
      end else begin
         // A completing buffer is never the one being handed off, so the two
         // updates below never touch the same full_q bit.
         if (cmpl_now) begin
            full_q[wr_sel_q] <= 1'b1;
            fill_cnt_q       <= fill_cnt_q + 1'b1;
            wr_sel_q         <= (NBUF == 2) ? ~wr_sel_q : 1'b0;
         end
         if (handoff) begin
            full_q[rd_sel_q] <= 1'b0;
            chunk_cnt_q      <= chunk_cnt_q + 1'b1;
            rd_sel_q         <= (NBUF == 2) ? ~rd_sel_q : 1'b0;
         end
      end
   end

   // Handoff register toward Preprocessing; holds between LOADs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         message   <= '0;
         indirizzo <= '0;
      end else if (handoff) begin
         message   <= asm_q[rd_sel_q];
         indirizzo <= ADDR_W'(chunk_cnt_q);
      end
   end

   // Sticky error flags: LOAD with nothing buffered, and s_last misplacement.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         underrun    <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         if ((fsm_q == FILL) && load) underrun <= 1'b1;
         if (word_acc && (s_last != (cmpl_now && last_fill))) framing_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mining_chunk_feeder.sv
// tb_mining_chunk_feeder: directed table, hand-written corner sequences and
// randomized traffic against a queue-based reference model of the feeder.
module tb_mining_chunk_feeder;

   localparam int NCHUNK = 2;
   localparam int WPC    = 16;
`ifdef MINING_FEEDER_DBUF_EN
   localparam int  NBUF           = 2;
   localparam bit  RDY_AFTER_FULL = 1'b1;
`else
   localparam int  NBUF           = 1;
   localparam bit  RDY_AFTER_FULL = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         s_valid = 1'b0;
   logic [31:0]  s_data = '0;
   logic         s_last = 1'b0;
   logic         s_ready;
   logic [2:0]   state = 3'h0;
   logic [511:0] message;
   logic [15:0]  indirizzo;
   logic         stopw, underrun, framing_err;

   int n_checks = 0;
   int n_fail   = 0;

   mining_chunk_feeder #(.MSG_BITS(1024), .WORD_W(32), .ADDR_W(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .state       (state),
      .message     (message),
      .indirizzo   (indirizzo),
      .stopw       (stopw),
      .underrun    (underrun),
      .framing_err (framing_err)
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   logic [511:0] m_chunks[$];   // assembled chunks, in arrival order
   logic [31:0]  m_words[WPC];  // words of the chunk under assembly
   int           m_wcnt, m_hand, m_idx;
   bit           m_started, m_under, m_frame;
   logic [511:0] m_msg;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      m_chunks.delete();
      m_wcnt = 0; m_hand = 0; m_idx = 0;
      m_started = 1'b0; m_under = 1'b0; m_frame = 1'b0;
      m_msg = '0;
   endtask

   function automatic bit model_ready();
      int pend = m_chunks.size() - m_hand;
      return m_started && (m_chunks.size() < NCHUNK) && (pend < NBUF);
   endfunction

   // One clock cycle: drive at negedge, check s_ready, apply edge, check outputs.
   task automatic step(input logic v, input logic [31:0] d, input logic l, input logic [2:0] st);
      bit rdy;
      bit fin;
      logic [511:0] c;
      @(negedge clock);
      s_valid = v; s_data = d; s_last = l; state = st;
      rdy = model_ready();
      #1 check("s_ready", s_ready, rdy);
      @(posedge clock);
      if (m_started && (m_hand < NCHUNK) && (st == 3'h1)) begin
         if (m_chunks.size() > m_hand) begin
            m_msg = m_chunks[m_hand];
            m_idx = m_hand;
            m_hand++;
         end else begin
            m_under = 1'b1;
         end
      end
      if (v && rdy) begin
         fin = (m_wcnt == WPC - 1) && (m_chunks.size() == NCHUNK - 1);
         if (l != fin) m_frame = 1'b1;
         m_words[m_wcnt] = d;
         m_wcnt++;
         if (m_wcnt == WPC) begin
            for (int k = 0; k < WPC; k++) c[511 - 32*k -: 32] = m_words[k];
            m_chunks.push_back(c);
            m_wcnt = 0;
         end
      end
      m_started = 1'b1;
      #1;
      check("message", message, m_msg);
      check("indirizzo", indirizzo, 16'(m_idx));
      check("stopw", stopw, m_hand == NCHUNK);
      check("underrun", underrun, m_under);
      check("framing_err", framing_err, m_frame);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      @(posedge clock);
      #2;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; state = 3'h0;
      reset = 1'b0;
      model_clear();
      #1;
      check("rst s_ready", s_ready, 1'b0);
      check("rst message", message, '0);
      check("rst indirizzo", indirizzo, '0);
      check("rst stopw", stopw, 1'b0);
      check("rst underrun", underrun, 1'b0);
      check("rst framing_err", framing_err, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      m_started = 1'b1;
   endtask

   // ---------------- directed table: full two-chunk message ----------------
   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        l;
      logic [2:0]  st;
      logic        exp_rdy;   // s_ready after the edge
      logic [31:0] exp_hi;    // message[511:480]
      logic [31:0] exp_lo;    // message[31:0]
      logic [15:0] exp_idx;
      logic        exp_stopw;
   } vec_t;

   vec_t vecs[35];

   task automatic run_table();
      for (int i = 0; i < 35; i++) begin
         step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].st);
         check($sformatf("s1[%0d] s_ready", i), s_ready, vecs[i].exp_rdy);
         check($sformatf("s1[%0d] msg_hi", i), message[511:480], vecs[i].exp_hi);
         check($sformatf("s1[%0d] msg_lo", i), message[31:0], vecs[i].exp_lo);
         check($sformatf("s1[%0d] indirizzo", i), indirizzo, vecs[i].exp_idx);
         check($sformatf("s1[%0d] stopw", i), stopw, vecs[i].exp_stopw);
      end
      check("s1 framing_err", framing_err, 1'b0);
      check("s1 underrun", underrun, 1'b0);
   endtask

   initial begin
      bit l;
      logic [2:0] st;

      for (int i = 0; i < 16; i++)
         vecs[i] = '{1'b1, 32'(i), 1'b0, 3'h0, (i == 15) ? RDY_AFTER_FULL : 1'b1,
                     32'h0, 32'h0, 16'h0, 1'b0};
      vecs[16] = '{1'b0, 32'h0, 1'b0, 3'h1, 1'b1, 32'h0, 32'hF, 16'h0, 1'b0};
      for (int i = 0; i < 16; i++)
         vecs[17 + i] = '{1'b1, 32'(16 + i), (i == 15), 3'h0, (i != 15),
                          32'h0, 32'hF, 16'h0, 1'b0};
      vecs[33] = '{1'b0, 32'h0, 1'b0, 3'h1, 1'b0, 32'h10, 32'h1F, 16'h1, 1'b1};
      vecs[34] = '{1'b0, 32'h0, 1'b0, 3'h1, 1'b0, 32'h10, 32'h1F, 16'h1, 1'b1};

      // Outputs while reset is held from time zero.
      #3;
      check("init s_ready", s_ready, 1'b0);
      check("init message", message, '0);
      check("init stopw", stopw, 1'b0);

      // Scenario 1: stream both chunks with a LOAD after each.
      do_reset();
      run_table();

      // Scenario 5: DONE ignores words and further LOADs.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b1, 3'h1);
         check("done msg_hi", message[511:480], 32'h10);
         check("done indirizzo", indirizzo, 16'h1);
         check("done stopw", stopw, 1'b1);
      end

      // Scenario 2: LOAD after five words is an underrun; chunk completes normally.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 3'h0);
      step(1'b0, 32'h0, 1'b0, 3'h1);
      check("s2 underrun", underrun, 1'b1);
      check("s2 message held", message, '0);
      for (int i = 5; i < 16; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 3'h0);
      step(1'b0, 32'h0, 1'b0, 3'h1);
      check("s2 msg_hi", message[511:480], 32'hA000_0000);
      check("s2 msg_lo", message[31:0], 32'hA000_000F);
      check("s2 indirizzo", indirizzo, 16'h0);

      // Scenario 3: s_last on word 7 of chunk 0 flags framing; word still used.
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 32'hB000_0000 + 32'(i), (i == 7), 3'h0);
         if (i == 6) check("s3 framing before", framing_err, 1'b0);
         if (i == 7) check("s3 framing at 7", framing_err, 1'b1);
      end
      step(1'b0, 32'h0, 1'b0, 3'h1);
      check("s3 word7", message[511 - 32*7 -: 32], 32'hB000_0007);
      check("s3 word15", message[31:0], 32'hB000_000F);

      // Missing s_last on the final word of the message.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         step(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 3'h0);
         if (i == 15) step(1'b0, 32'h0, 1'b0, 3'h1);
         if (i == 30) check("s7 framing before last", framing_err, 1'b0);
      end
      check("s7 framing missing last", framing_err, 1'b1);

      // Scenario 4: reset mid chunk 1 (word 9), then restream reproduces scenario 1.
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 32'(i), 1'b0, 3'h0);
      step(1'b0, 32'h0, 1'b0, 3'h1);
      for (int i = 16; i < 25; i++) step(1'b1, 32'(i), 1'b0, 3'h0);
      check("s4 message before reset", message[511:480], 32'h0);
      check("s4 indirizzo before reset", indirizzo, 16'h0);
      do_reset();
      run_table();

`ifdef MINING_FEEDER_DBUF_EN
      // Scenario 6: with two buffers, all 32 words stream without waiting.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         check("s6 s_ready streaming", s_ready, 1'b1);
         step(1'b1, 32'hD000_0000 + 32'(i), (i == 31), 3'h0);
      end
      step(1'b0, 32'h0, 1'b0, 3'h1);
      check("s6 chunk0 hi", message[511:480], 32'hD000_0000);
      check("s6 chunk0 idx", indirizzo, 16'h0);
      step(1'b0, 32'h0, 1'b0, 3'h1);
      check("s6 chunk1 hi", message[511:480], 32'hD000_0010);
      check("s6 chunk1 idx", indirizzo, 16'h1);
      check("s6 stopw", stopw, 1'b1);
`endif

      // Randomized traffic against the model.
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int c = 0; c < 300; c++) begin
            if (r % 2 == 0) l = (m_wcnt == WPC - 1) && (m_chunks.size() == NCHUNK - 1);
            else            l = ($urandom_range(0, 15) == 0);
            st = ($urandom_range(0, 5) == 0) ? 3'h1 : 3'($urandom_range(2, 7));
            step($urandom_range(0, 3) != 0, $urandom, l, st);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
